// File: rtl/student_bram_sdp.sv
// -----------------------------------------------------------------------------
// student_bram_sdp
// Simple dual-port block RAM for sample storage in the audio/FIR datapath.
// One synchronous write port and one synchronous read port share one clock.
// The read side is registered and read-first on address collisions.
//
// Parameters (positional order fixed):
//   ADDR_WIDTH  address width; depth is 2**ADDR_WIDTH words
//   DATA_WIDTH  word width in bits
//
// Ports:
//   clk_i   in   single clock, rising edge
//   rst_i   in   synchronous active-high reset; clears only rdata
//   wvalid  in   write enable
//   wdata   in   write data
//   waddr   in   write address
//   raddr   in   read address
//   rdata   out  registered read data, one cycle after raddr
// -----------------------------------------------------------------------------
module student_bram_sdp #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wvalid,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Power-up contents are zero; the array itself is never reset so that
    // it still maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // Writes are honoured even while rst_i is high.
    always_ff @(posedge clk_i) begin
        if (wvalid) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the array gives the pre-write content on a
    // same-address collision (read-first).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: tb/tb_student_bram_sdp.sv
module tb_student_bram_sdp;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk_i;
    logic          rst_i;
    logic          wvalid;
    logic [DW-1:0] wdata;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    student_bram_sdp #(AW, DW) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .wvalid (wvalid),
        .wdata  (wdata),
        .waddr  (waddr),
        .raddr  (raddr),
        .rdata  (rdata)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic          rs;
    } stim_t;

    // Reference memory; unwritten locations read as zero.
    logic [DW-1:0] model [logic [AW-1:0]];
    logic [DW-1:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] got;
    logic [DW-1:0] exp_v;

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (model.exists(a)) return model[a];
        return '0;
    endfunction

    // Drive one cycle; the expected rdata after this edge is queued before
    // the model applies the write, which gives read-first behaviour.
    task automatic step(input stim_t s);
        @(negedge clk_i);
        wvalid = s.wv;
        waddr  = s.wa;
        wdata  = s.wd;
        raddr  = s.ra;
        rst_i  = s.rs;
        exp_q.push_back(s.rs ? '0 : model_rd(s.ra));
        if (s.wv) model[s.wa] = s.wd;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        stim_t t [3];
        t = '{'{1'b0, 16'd0, 16'd0, 16'd5, 1'b1},
              '{1'b0, 16'd0, 16'd0, 16'd5, 1'b1},
              '{1'b0, 16'd0, 16'd0, 16'd5, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            step(t[i]);
            got = rdata;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL reset[%0d]: rdata=%h expected=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_write_read();
        stim_t t [4];
        t = '{'{1'b1, 16'd1, 16'd0,  16'd0, 1'b0},
              '{1'b0, 16'd0, 16'd0,  16'd1, 1'b0},
              '{1'b1, 16'd3, 16'd10, 16'd1, 1'b0},
              '{1'b0, 16'd0, 16'd0,  16'd3, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            step(t[i]);
            got = rdata;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL write_read[%0d]: rdata=%h expected=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_masking();
        stim_t t [4];
        t = '{'{1'b0, 16'd2, 16'd4, 16'd2, 1'b0},
              '{1'b0, 16'd0, 16'd0, 16'd2, 1'b0},
              '{1'b1, 16'd4, 16'd6, 16'd2, 1'b0},
              '{1'b0, 16'd0, 16'd0, 16'd4, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            step(t[i]);
            got = rdata;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL masking[%0d]: rdata=%h expected=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_collision();
        stim_t t [3];
        t = '{'{1'b1, 16'd7, 16'h1111, 16'd0, 1'b0},
              '{1'b1, 16'd7, 16'h2222, 16'd7, 1'b0},
              '{1'b0, 16'd0, 16'h0000, 16'd7, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            step(t[i]);
            got = rdata;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL collision[%0d]: rdata=%h expected=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        for (int i = 0; i <= 16; i++) begin
            s.wv = (i < 16);
            s.wa = AW'(i);
            s.wd = DW'(i * 3);
            s.ra = AW'(i - 1);
            s.rs = 1'b0;
            step(s);
            got = rdata;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: rdata=%h expected=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_boundary();
        stim_t t [5];
        t = '{'{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0},
              '{1'b1, 16'h0000, 16'hA5A5, 16'hFFFF, 1'b0},
              '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0},
              '{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0},
              '{1'b0, 16'h0000, 16'h0000, 16'h7FFF, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            step(t[i]);
            got = rdata;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL boundary[%0d]: rdata=%h expected=%h", i, got, exp_v);
            end
        end
    endtask

    // Reset in mid-stream on a location holding data, with a write issued
    // during the reset cycle that must still land.
    task automatic test_mid_reset();
        stim_t t [4];
        t = '{'{1'b0, 16'd0, 16'h0000, 16'd3, 1'b0},
              '{1'b1, 16'd9, 16'h3333, 16'd3, 1'b1},
              '{1'b0, 16'd0, 16'h0000, 16'd9, 1'b0},
              '{1'b0, 16'd0, 16'h0000, 16'd3, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            step(t[i]);
            got = rdata;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL mid_reset[%0d]: rdata=%h expected=%h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        rst_i  = 1'b1;
        wvalid = 1'b0;
        wdata  = '0;
        waddr  = '0;
        raddr  = '0;
        test_reset();
        test_write_read();
        test_masking();
        test_collision();
        test_back_to_back();
        test_boundary();
        test_mid_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t limit=100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
